// File: rtl/alu_serial_unit.sv
// ---------------------------------------------------------------------------
// alu_serial_unit
//
// Slice-serial ALU with a valid/ready request and response handshake.
// A request (f, a, b) is captured in IDLE. It is processed SLICE bits per
// cycle, LSB slice first, in BUSY, using a registered carry chain. The
// result is then presented in DONE until the initiator takes it. The
// function encoding and flags match the combinational alu.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE only)
//   f[2:0]     f[2]: invert b, carry-in 1; f[1:0]: 00 AND, 01 OR, 10 SUM, 11 SLT
//   a, b       WIDTH-bit operands
//   out_valid  result valid (DONE only)
//   out_ready  initiator accepts the result
//   y          WIDTH-bit result, held until the next DONE or reset
//   zero       y == 0
//   carry_out  adder carry out of the MSB
//   overflow   signed overflow of the adder
// ---------------------------------------------------------------------------
module alu_serial_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, bb_q, sum_q;
    logic [2:0]       f_q;

    logic             accept, last_slice;
    int               base;
    logic [SLICE-1:0] a_s, b_s, s_s;
    logic             c_next, c_msb, ov;
    logic [WIDTH-1:0] sum_full, y_d;
    logic             cf_d, ov_d;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign accept     = in_ready && in_valid;
    assign last_slice = (state_q == BUSY) && (cnt_q == LAST);

    // Next-state logic.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Current slice of the adder. The carry into the slice MSB is recovered
    // as a ^ b ^ sum at that bit, which gives the signed-overflow term.
    always_comb begin
        base = int'(cnt_q) * SLICE;
        a_s  = a_q[base +: SLICE];
        b_s  = bb_q[base +: SLICE];
        {c_next, s_s} = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        c_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ s_s[SLICE-1];
        ov    = c_msb ^ c_next;
        // Sum slices gathered so far, with the slice being computed now.
        sum_full = sum_q;
        sum_full[base +: SLICE] = s_s;
    end

    // Result selection. It is only meaningful during the last slice.
    always_comb begin
        y_d  = '0;
        cf_d = 1'b0;
        ov_d = 1'b0;
        case (f_q[1:0])
            2'b00: y_d = a_q & bb_q;
            2'b01: y_d = a_q | bb_q;
            2'b10: begin
                y_d  = sum_full;
                cf_d = c_next;
                ov_d = ov;
            end
            default: begin
                y_d[0] = sum_full[WIDTH-1] ^ ov;
                cf_d   = c_next;
                ov_d   = ov;
            end
        endcase
    end

    // Operand and partial-sum storage. A reset cannot make these visible,
    // because they are always written before they are read.
    // NOTE: datapath registers are left without a reset. Only control state
    // and the visible outputs need a defined value after reset_n.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            bb_q <= f[2] ? ~b : b;
            f_q  <= f;
        end
        if (state_q == BUSY) sum_q[base +: SLICE] <= s_s;
    end

    // Control state and held outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= '0;
                carry_q <= f[2];
            end else if (state_q == BUSY) begin
                carry_q <= c_next;
                cnt_q   <= last_slice ? '0 : cnt_q + 1'b1;
            end
            if (last_slice) begin
                y         <= y_d;
                zero      <= (y_d == '0);
                carry_out <= cf_d;
                overflow  <= ov_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_unit
//
// Directed bench for alu_serial_unit with the default parameters
// (WIDTH 8, SLICE 4). Inputs change on the falling edge, and outputs are
// sampled on the falling edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_serial_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] f;
    logic [7:0] a, b, y;
    logic       zero, carry_out, overflow;

    int tests = 0;
    int fails = 0;

    alu_serial_unit #(.WIDTH(8), .SLICE(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge, wait for the accepting rising
    // edge, then measure the number of rising edges until out_valid.
    task automatic issue(input logic [2:0] fi, input logic [7:0] ai, input logic [7:0] bi,
                         output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_issue", in_ready, 1);
        f = fi; a = ai; b = bi; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        f = 3'b000; a = 8'h00; b = 8'h00;   // later changes must be ignored
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        lat--;   // edges after acceptance
    endtask

    task automatic run_op(input string tag, input logic [2:0] fi, input logic [7:0] ai,
                          input logic [7:0] bi, input logic [7:0] ey, input logic ez,
                          input logic ec, input logic ev);
        int lat;
        issue(fi, ai, bi, lat);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_y"}, y, ey);
        check({tag, "_flags"}, {zero, carry_out, overflow}, {ez, ec, ev});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ret_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int lat;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        f = 3'b000; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", {in_ready, out_valid, y, zero, carry_out, overflow},
              {1'b1, 1'b0, 8'h00, 3'b000});
        reset_n = 1'b1;
        @(negedge clk);

        run_op("add",  3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        run_op("sub",  3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("slt1", 3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
        run_op("slt2", 3'b111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("and",  3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or",   3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);

        // Backpressure: result held, new request ignored while in DONE.
        issue(3'b010, 8'h7F, 8'h01, lat);
        check("bp_latency", lat, 2);
        f = 3'b110; a = 8'h0A; b = 8'h03; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {in_ready, out_valid, y, zero, carry_out, overflow},
                  {1'b0, 1'b1, 8'h80, 3'b001});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);
        check("bp_y_held_idle", y, 8'h80);
        @(posedge clk);            // the pending request is accepted here
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("bp_new_latency", lat - 1, 2);
        // 0A - 03 = 07 with carry out, no overflow
        check("bp_new_result", {y, zero, carry_out, overflow}, {8'h07, 3'b010});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset one cycle after acceptance.
        f = 3'b010; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_busy_before", {in_ready, out_valid}, 2'b00);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check("rst_immediate", {in_ready, out_valid, y, zero, carry_out, overflow},
                 {1'b1, 1'b0, 8'h00, 3'b000});
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_stale", {in_ready, out_valid, y}, {1'b1, 1'b0, 8'h00});
        run_op("post_rst_add", 3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_serial_unit.md
# alu_serial_unit

Multi-cycle, slice-serial ALU that acts as the responder on a request/response handshake. It accepts an operation and two WIDTH-bit operands from an initiator, such as a bench or sequencer, and processes SLICE bits per clock, LSB slice first, with a registered carry chain. It then presents y, zero, carry_out and overflow until the initiator takes them. The function encoding and flag semantics match the team's combinational `alu`, so the same test vectors remain valid against this unit.

## Interface
- WIDTH, 8, operand/result width; must be a positive multiple of SLICE
- SLICE, 4, bits processed per BUSY cycle; 1 ≤ SLICE ≤ WIDTH
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request (high only in IDLE)
- f  input  3  function: f[2] = invert b with carry-in 1; f[1:0] = 00 AND, 01 OR, 10 SUM, 11 SLT
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  initiator accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- carry_out  output  1  adder carry out of the MSB
- overflow  output  1  signed overflow of the adder

## Operation
- States: IDLE, BUSY, DONE. Slice counter spans 0..WIDTH/SLICE−1.
- IDLE: in_ready=1. On in_valid at a rising edge, register a, b and f, and load the carry register with f[2]. Set counter=0 and go to BUSY. Later changes on a, b or f are ignored.
- BUSY: each cycle processes slice k (bits k·SLICE .. k·SLICE+SLICE−1).
  - bb = f[2] ? ~b : b.
  - AND/OR slices: computed bitwise.
  - Adder slices: a + bb + carry, with the carry register updated.
  - Last slice: also capture the carry into the MSB (c_msb) and the carry out (c_out).
  - After the last slice, go to DONE.
- Result on entry to DONE, registered:
  - f[1:0]=00: y = a & bb. carry_out = 0, overflow = 0.
  - f[1:0]=01: y = a | bb. carry_out = 0, overflow = 0.
  - f[1:0]=10: y = sum. carry_out = c_out, overflow = c_msb ^ c_out.
  - f[1:0]=11: y = {0…, sum[WIDTH−1] ^ overflow}. carry_out and overflow are reported as for 10.
  - zero = (y == 0) in all cases.
- DONE: out_valid=1. y and all flags are held stable. When out_ready is high at a rising edge, go to IDLE and clear out_valid.
- Requests are never overlapped. in_valid outside IDLE is ignored and causes no capture or error.
- Reset (async, any state):
  - state=IDLE, counter=0, carry=0.
  - Outputs: in_ready=1, out_valid=0, y=0, zero=0, carry_out=0, overflow=0.
  - An operation in flight is discarded and produces no result.

## Timing
- Accept edge E0 (in_valid & in_ready). The slice edges are E1..E_{WIDTH/SLICE}.
- out_valid rises after edge E_{WIDTH/SLICE}. For defaults this is 2 cycles after acceptance.
- Return to IDLE on the out_valid & out_ready edge. in_ready is high in the following cycle.
- Minimum request-to-request spacing: WIDTH/SLICE + 2 cycles (defaults: 4).
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- y and flags change only on entry to DONE or on reset. They are held through IDLE until the next DONE.
- SLICE = WIDTH: single BUSY cycle, so out_valid appears 1 cycle after acceptance.

## Test plan
- ADD, f=010, a=7F, b=01 -> out_valid 2 cycles after accept. y=80, zero=0, carry_out=0, overflow=1.
- SUB, f=110, a=05, b=05 -> y=00, zero=1, carry_out=1, overflow=0.
- SLT, f=111, a=80, b=01 -> y=01, zero=0, carry_out=1, overflow=1. Then a=01, b=80 -> y=00, zero=1.
- AND, f=000, a=F0, b=3C -> y=30, flags 0. OR, f=001 -> y=FC.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and drive in_valid with new operands -> y and flags stable, in_ready=0, no capture. Releasing out_ready gives in_ready=1 the next cycle, and the new request is accepted then.
- Reset mid-BUSY: assert reset_n=0 one cycle after accept -> immediate in_ready=1, out_valid=0, y=00. After release, a fresh ADD 01+01 returns y=02 with no stale result.
